bsk_prm_seq: RTL and testbench

Synchronous host-side sequencer for the BskPRM command-receiver bus slave. Turns a 16-bit command request (valid/ready) into the PRM bus transactions. After reset it unlocks the slave by writing the enable key to register 11. It then writes each command as byte/complement pairs to registers 00 and 01 and the indication word to register 10. It sits between the system controller and the PRM board connector, generating CS, address, and active-low read/write strobes with programmable setup, strobe and hold times.

---
 rtl/bsk_prm_pkg.sv | 47 ++++
 rtl/bsk_bus_cycle.sv | 96 +++++++++
 rtl/bsk_prm_seq.sv | 185 ++++++++++++++++++
 tb/tb_bsk_prm_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsk_prm_pkg.sv
// Shared types and constants for the BskPRM host-side sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package bsk_prm_pkg;

    // Slave handshake values
    localparam logic [7:0] PASSWORD   = 8'hA6;
    localparam logic [7:0] ENABLE_KEY = 8'hE1;

    // Bus phase lengths in clocks, each 1..15
    localparam int T_SETUP  = 2;
    localparam int T_STROBE = 4;
    localparam int T_HOLD   = 2;

    // Enable attempts before giving up
    localparam logic [1:0] MAX_RETRY = 2'd3;

    // Register map of the slave
    localparam logic [1:0] ADDR_TEST   = 2'b00;
    localparam logic [1:0] ADDR_CMD_LO = 2'b00;
    localparam logic [1:0] ADDR_CMD_HI = 2'b01;
    localparam logic [1:0] ADDR_IND    = 2'b10;
    localparam logic [1:0] ADDR_CTRL   = 2'b11;

    // Phase counter reload values (counts down to zero)
    localparam logic [3:0] CNT_SETUP  = 4'(T_SETUP - 1);
    localparam logic [3:0] CNT_STROBE = 4'(T_STROBE - 1);
    localparam logic [3:0] CNT_HOLD   = 4'(T_HOLD - 1);

    typedef enum logic [2:0] {
        ST_ENABLE,
        ST_CHECK,
        ST_IDLE,
        ST_CMD_LO,
        ST_CMD_HI,
        ST_IND,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

endpackage

// File: rtl/bsk_bus_cycle.sv
// Single PRM bus transaction engine: SETUP, STROBE, HOLD phases with CS/address/data held throughout.
// Latency: T_SETUP+T_STROBE+T_HOLD clocks per transaction; done is high during the last HOLD clock.
// Backpressure: start is taken when idle or when done is high, giving back-to-back cycles with no gap.
module bsk_bus_cycle
    import bsk_prm_pkg::*;
(
    input  logic        iClk,
    input  logic        iRes,
    input  logic        i_start,
    input  logic        i_rnw,
    input  logic [1:0]  i_addr,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_rd_d,
    output logic        o_done,
    output logic        o_idle,
    output logic [15:0] o_rdata,
    output logic        o_cs_n,
    output logic [1:0]  o_a,
    output logic        o_wr_n,
    output logic        o_rd_n,
    output logic [15:0] o_d,
    output logic        o_doe
);

    phase_t      r_phase;
    logic [3:0]  r_cnt;
    logic        r_rnw;
    logic [1:0]  r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;

    assign o_idle  = (r_phase == PH_IDLE);
    assign o_done  = (r_phase == PH_HOLD) && (r_cnt == 4'd0);
    assign o_rdata = r_rdata;

    // Pins decode straight from registered phase state, so reset clears them on the next edge
    assign o_cs_n = (r_phase == PH_IDLE);
    assign o_a    = r_addr;
    assign o_wr_n = !((r_phase == PH_STROBE) && !r_rnw);
    assign o_rd_n = !((r_phase == PH_STROBE) && r_rnw);
    assign o_d    = r_wdata;
    assign o_doe  = (r_phase != PH_IDLE) && !r_rnw;

    // Phase sequencer; read data is captured on the edge that closes the last STROBE clock
    always_ff @(posedge iClk) begin
        if (iRes) begin
            r_phase <= PH_IDLE;
            r_cnt   <= 4'd0;
            r_rnw   <= 1'b0;
            r_addr  <= 2'b00;
            r_wdata <= 16'h0000;
            r_rdata <= 16'h0000;
        end else if (i_start && (o_idle || o_done)) begin
            r_phase <= PH_SETUP;
            r_cnt   <= CNT_SETUP;
            r_rnw   <= i_rnw;
            r_addr  <= i_addr;
            if (!i_rnw) begin
                r_wdata <= i_wdata;
            end
        end else begin
            case (r_phase)
                PH_SETUP: begin
                    if (r_cnt == 4'd0) begin
                        r_phase <= PH_STROBE;
                        r_cnt   <= CNT_STROBE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                PH_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_phase <= PH_HOLD;
                        r_cnt   <= CNT_HOLD;
                        if (r_rnw) begin
                            r_rdata <= i_rd_d;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                PH_HOLD: begin
                    if (r_cnt == 4'd0) begin
                        r_phase <= PH_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_phase <= PH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/bsk_prm_seq.sv
// Host sequencer for the BskPRM slave: unlock, then write each command as byte/complement pairs plus indication word.
// Latency: accept edge to oDone pulse is 3N+1 clocks (N = setup+strobe+hold); oCmdReady returns the clock after oDone.
// Backpressure: oCmdReady only in IDLE; define BSK_PRM_SEQ_READBACK_EN to add the unlock read-back check, oErr and FAULT.
module bsk_prm_seq
    import bsk_prm_pkg::*;
(
    input  logic        iClk,
    input  logic        iRes,
    input  logic        iCmdValid,
    output logic        oCmdReady,
    input  logic [15:0] iCmd,
    input  logic [15:0] iInd,
    output logic        oDone,
    output logic        oBusy,
    output logic        oErr,
    output logic        oCS,
    output logic [1:0]  oA,
    output logic        oWr,
    output logic        oRd,
    output logic [15:0] oD,
    output logic        oDOe,
    input  logic [15:0] iD
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cmd;
    logic [15:0] r_ind;
    logic        r_done;

    logic        w_req;
    logic        w_start;
    logic        w_rnw;
    logic [1:0]  w_addr;
    logic [15:0] w_wdata;
    logic        w_eng_done;
    logic        w_eng_idle;
    logic [15:0] w_rdata;
    logic        w_accept;

    // Ready is held off for the oDone cycle so the two never overlap
    assign oCmdReady = (r_state == ST_IDLE) && !r_done;
    assign w_accept  = iCmdValid && oCmdReady;
    assign oBusy     = (r_state != ST_IDLE);
    assign oDone     = r_done;

`ifdef BSK_PRM_SEQ_READBACK_EN
    logic       w_pass;
    logic [1:0] r_retry;
    logic       r_err;

    assign w_pass = (w_rdata[15:8] == PASSWORD) && !w_rdata[0];
    assign oErr   = r_err;

    // Sticky error and retry count, both updated when a CHECK read fails
    always_ff @(posedge iClk) begin
        if (iRes) begin
            r_retry <= 2'd0;
            r_err   <= 1'b0;
        end else if ((r_state == ST_CHECK) && w_eng_done && !w_pass) begin
            r_retry <= r_retry + 2'd1;
            r_err   <= 1'b1;
        end
    end
`else
    logic w_unused_rdata;

    assign w_unused_rdata = ^w_rdata;
    assign oErr           = 1'b0;
`endif

    // Next-state logic; every bus state advances when its transaction finishes
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ENABLE: begin
                if (w_eng_done) begin
`ifdef BSK_PRM_SEQ_READBACK_EN
                    w_next = ST_CHECK;
`else
                    w_next = ST_IDLE;
`endif
                end
            end
            ST_CHECK: begin
`ifdef BSK_PRM_SEQ_READBACK_EN
                if (w_eng_done) begin
                    if (w_pass) begin
                        w_next = ST_IDLE;
                    end else if (r_retry == MAX_RETRY - 2'd1) begin
                        w_next = ST_FAULT;
                    end else begin
                        w_next = ST_ENABLE;
                    end
                end
`else
                w_next = ST_ENABLE;
`endif
            end
            ST_IDLE:   if (w_accept)   w_next = ST_CMD_LO;
            ST_CMD_LO: if (w_eng_done) w_next = ST_CMD_HI;
            ST_CMD_HI: if (w_eng_done) w_next = ST_IND;
            ST_IND:    if (w_eng_done) w_next = ST_IDLE;
            ST_FAULT:  w_next = ST_FAULT;
            default:   w_next = ST_ENABLE;
        endcase
    end

    // Transaction request for the upcoming state; issued on the finishing clock of the previous
    // cycle (zero gap) or, on first entry, once the state register has caught up
    always_comb begin
        w_req   = 1'b0;
        w_rnw   = 1'b0;
        w_addr  = ADDR_CTRL;
        w_wdata = 16'h0000;
        case (w_next)
            ST_ENABLE: begin
                w_req   = 1'b1;
                w_addr  = ADDR_CTRL;
                w_wdata = {8'h00, ENABLE_KEY};
            end
            ST_CHECK: begin
                w_req  = 1'b1;
                w_rnw  = 1'b1;
                w_addr = ADDR_CTRL;
            end
            ST_CMD_LO: begin
                w_req   = 1'b1;
                w_addr  = ADDR_CMD_LO;
                w_wdata = {~r_cmd[7:0], r_cmd[7:0]};
            end
            ST_CMD_HI: begin
                w_req   = 1'b1;
                w_addr  = ADDR_CMD_HI;
                w_wdata = {~r_cmd[15:8], r_cmd[15:8]};
            end
            ST_IND: begin
                w_req   = 1'b1;
                w_addr  = ADDR_IND;
                w_wdata = r_ind;
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
        w_start = w_req && (w_eng_done || ((w_next == r_state) && w_eng_idle));
    end

    // State register, command latches and the completion pulse
    always_ff @(posedge iClk) begin
        if (iRes) begin
            r_state <= ST_ENABLE;
            r_cmd   <= 16'h0000;
            r_ind   <= 16'h0000;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_IND) && w_eng_done;
            if (w_accept) begin
                r_cmd <= iCmd;
                r_ind <= iInd;
            end
        end
    end

    bsk_bus_cycle u_bus (
        .iClk    (iClk),
        .iRes    (iRes),
        .i_start (w_start),
        .i_rnw   (w_rnw),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .i_rd_d  (iD),
        .o_done  (w_eng_done),
        .o_idle  (w_eng_idle),
        .o_rdata (w_rdata),
        .o_cs_n  (oCS),
        .o_a     (oA),
        .o_wr_n  (oWr),
        .o_rd_n  (oRd),
        .o_d     (oD),
        .o_doe   (oDOe)
    );

endmodule

// File: tb/tb_bsk_prm_seq.sv
// Scoreboard bench for bsk_prm_seq: expected bus transactions are queued when driven and checked at each strobe.
// Latency: checks unlock-to-ready, 3N+1 command latency and per-phase pin timing.
// Backpressure: commands are only offered while oCmdReady is high.
module tb_bsk_prm_seq;

    localparam int N      = 8;
    localparam int T_SET  = 2;
    localparam int T_STR  = 4;

    typedef struct {
        logic        we;
        logic [1:0]  a;
        logic [15:0] d;
    } bus_t;

    logic        iClk;
    logic        iRes;
    logic        iCmdValid;
    logic        oCmdReady;
    logic [15:0] iCmd;
    logic [15:0] iInd;
    logic        oDone;
    logic        oBusy;
    logic        oErr;
    logic        oCS;
    logic [1:0]  oA;
    logic        oWr;
    logic        oRd;
    logic [15:0] oD;
    logic        oDOe;
    logic [15:0] iD;

    logic [15:0] slave_d;
    bus_t        exp_q[$];
    int          n_chk;
    int          n_fail;
    logic        mon_en;
    logic        saw_rd;

    // monitor state
    int          t_now;
    int          cs_fall_t;
    int          last_fall_t;
    int          burst_cnt;
    int          str_len;
    logic        p_cs;
    logic        p_str;
    logic [15:0] str_d;

    assign iD = slave_d;

    bsk_prm_seq dut (
        .iClk      (iClk),
        .iRes      (iRes),
        .iCmdValid (iCmdValid),
        .oCmdReady (oCmdReady),
        .iCmd      (iCmd),
        .iInd      (iInd),
        .oDone     (oDone),
        .oBusy     (oBusy),
        .oErr      (oErr),
        .oCS       (oCS),
        .oA        (oA),
        .oWr       (oWr),
        .oRd       (oRd),
        .oD        (oD),
        .oDOe      (oDOe),
        .iD        (iD)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [1:0] a, input logic [15:0] d);
        bus_t e;
        e.we = we;
        e.a  = a;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic push_enable();
        push_bus(1'b1, 2'b11, 16'h00E1);
`ifdef BSK_PRM_SEQ_READBACK_EN
        push_bus(1'b0, 2'b11, 16'h0000);
`endif
    endtask

    // Bus monitor: sampled on the falling edge, checks phase timing and pops the scoreboard at each strobe fall
    always @(negedge iClk) begin
        t_now++;
        if (oRd === 1'b0) saw_rd = 1'b1;
        if (iRes || !mon_en) begin
            p_cs      = 1'b1;
            p_str     = 1'b1;
            burst_cnt = 0;
            str_len   = 0;
        end else begin
            if (p_cs && !oCS) cs_fall_t = t_now;
            if (!(oWr && oRd)) begin
                if (p_str) begin
                    str_len = 0;
                    if (burst_cnt == 0) check_val("setup after cs", 32'(t_now - cs_fall_t), 32'(T_SET));
                    else                check_val("strobe period", 32'(t_now - last_fall_t), 32'(N));
                    last_fall_t = t_now;
                    burst_cnt++;
                    check_val("bus cycle expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        bus_t e;
                        e = exp_q.pop_front();
                        check_val("write not read", 32'(!oWr), 32'(e.we));
                        check_val("addr", 32'(oA), 32'(e.a));
                        if (e.we) check_val("wdata", 32'(oD), 32'(e.d));
                    end
                    str_d = oD;
                end
                str_len++;
                if (!oWr) begin
                    check_val("doe on write", 32'(oDOe), 32'd1);
                    check_val("wdata stable", 32'(oD), 32'(str_d));
                end else begin
                    check_val("doe on read", 32'(oDOe), 32'd0);
                end
            end else if (!p_str) begin
                check_val("strobe width", 32'(str_len), 32'(T_STR));
            end
            if (!p_cs && oCS) begin
                check_val("cs low length", 32'(t_now - cs_fall_t), 32'(N * burst_cnt));
                burst_cnt = 0;
            end
            p_cs  = oCS;
            p_str = oWr && oRd;
        end
    end

    // Clocks from the caller's point (just after an edge) until oCmdReady is seen high
    task automatic count_ready(output int n);
        n = 0;
        while (n < 300) begin
            @(posedge iClk);
            n++;
            @(negedge iClk);
            if (oCmdReady) break;
        end
    endtask

    task automatic send_cmd(input logic [15:0] c, input logic [15:0] ind);
        int k;
        k = 0;
        while (!oCmdReady && k < 300) begin
            @(negedge iClk);
            k++;
        end
        check_val("ready before cmd", 32'(oCmdReady), 32'd1);
        push_bus(1'b1, 2'b00, {~c[7:0], c[7:0]});
        push_bus(1'b1, 2'b01, {~c[15:8], c[15:8]});
        push_bus(1'b1, 2'b10, ind);
        iCmd      = c;
        iInd      = ind;
        iCmdValid = 1'b1;
        @(posedge iClk);
        #1;
        iCmdValid = 1'b0;
        iCmd      = ~c;
        iInd      = ~ind;
        check_val("busy after accept", 32'(oBusy), 32'd1);
    endtask

    task automatic do_cmd(input logic [15:0] c, input logic [15:0] ind);
        int k;
        send_cmd(c, ind);
        k = 0;
        while (k < 300) begin
            @(posedge iClk);
            k++;
            @(negedge iClk);
            if (oDone) break;
        end
        check_val("cmd latency", 32'(k), 32'(3 * N + 1));
        check_val("ready during done", 32'(oCmdReady), 32'd0);
        @(negedge iClk);
        check_val("done one cycle", 32'(oDone), 32'd0);
        check_val("ready after done", 32'(oCmdReady), 32'd1);
    endtask

    initial begin
        int n;
        n_chk     = 0;
        n_fail    = 0;
        t_now     = 0;
        saw_rd    = 1'b0;
        mon_en    = 1'b1;
        iRes      = 1'b1;
        iCmdValid = 1'b0;
        iCmd      = 16'h0000;
        iInd      = 16'h0000;
        slave_d   = 16'hA65A;

        // reset state
        repeat (3) @(posedge iClk);
        #1;
        check_val("rst oCS", 32'(oCS), 32'd1);
        check_val("rst oWr", 32'(oWr), 32'd1);
        check_val("rst oRd", 32'(oRd), 32'd1);
        check_val("rst oDOe", 32'(oDOe), 32'd0);
        check_val("rst oD", 32'(oD), 32'd0);
        check_val("rst oA", 32'(oA), 32'd0);
        check_val("rst oCmdReady", 32'(oCmdReady), 32'd0);
        check_val("rst oDone", 32'(oDone), 32'd0);
        check_val("rst oBusy", 32'(oBusy), 32'd1);
        check_val("rst oErr", 32'(oErr), 32'd0);

        // unlock sequence after release
        push_enable();
        iRes = 1'b0;
        count_ready(n);
`ifdef BSK_PRM_SEQ_READBACK_EN
        check_val("ready after unlock", 32'(n), 32'(2 * N + 1));
`else
        check_val("ready after unlock", 32'(n), 32'(N + 1));
`endif
        check_val("unlock consumed", 32'(exp_q.size()), 32'd0);
        check_val("no err after unlock", 32'(oErr), 32'd0);
        check_val("idle not busy", 32'(oBusy), 32'd0);

        // directed command, then random back-to-back commands
        do_cmd(16'h87A5, 16'h1234);
        do_cmd(16'h0001, 16'hFFFF);
        do_cmd(16'h8000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            do_cmd(16'($urandom), 16'($urandom));
        end
        check_val("cmds consumed", 32'(exp_q.size()), 32'd0);

        // reset during the CMD_HI strobe
        send_cmd(16'hC33C, 16'h5A5A);
        n = 0;
        while (!(oA == 2'b01 && !oWr) && n < 300) begin
            @(negedge iClk);
            n++;
        end
        check_val("reached cmd_hi strobe", 32'(oA == 2'b01 && !oWr), 32'd1);
        mon_en = 1'b0;
        iRes   = 1'b1;
        @(posedge iClk);
        #1;
        check_val("midrst oWr", 32'(oWr), 32'd1);
        check_val("midrst oCS", 32'(oCS), 32'd1);
        check_val("midrst oDOe", 32'(oDOe), 32'd0);
        check_val("midrst oCmdReady", 32'(oCmdReady), 32'd0);
        exp_q.delete();
        mon_en = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        push_enable();
        iRes = 1'b0;
        count_ready(n);
`ifdef BSK_PRM_SEQ_READBACK_EN
        check_val("ready after restart", 32'(n), 32'(2 * N + 1));
`else
        check_val("ready after restart", 32'(n), 32'(N + 1));
`endif
        check_val("restart consumed", 32'(exp_q.size()), 32'd0);
        do_cmd(16'h3C96, 16'hBEEF);

`ifdef BSK_PRM_SEQ_READBACK_EN
        // read-back always fails: three unlock attempts then FAULT
        slave_d = 16'hA65B;
        iRes    = 1'b1;
        @(posedge iClk);
        #1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) push_enable();
        iRes = 1'b0;
        repeat (2 * N) @(posedge iClk);
        #1;
        check_val("err before first check ends", 32'(oErr), 32'd0);
        @(posedge iClk);
        #1;
        check_val("err after first check", 32'(oErr), 32'd1);
        n = 0;
        for (int i = 0; i < 6 * N + 100; i++) begin
            @(negedge iClk);
            if (oCmdReady) n++;
        end
        check_val("fault ready never", 32'(n), 32'd0);
        check_val("fault busy", 32'(oBusy), 32'd1);
        check_val("fault bus idle", 32'(oCS), 32'd1);
        check_val("fault err sticky", 32'(oErr), 32'd1);
        check_val("fault attempts", 32'(exp_q.size()), 32'd0);
        check_val("reads generated", 32'(saw_rd), 32'd1);
`else
        check_val("no read strobes", 32'(saw_rd), 32'd0);
        check_val("err tied low", 32'(oErr), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
